// File: rtl/t5_pkg.sv
// Shared types and helpers for the t5 data-bus RAM responder: FSM states,
// byte-select encodings, select legality check and store lane merge.
package t5_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WT,
      ST_RESP,
      ST_ERR
   } state_e;

   localparam logic [3:0] SEL_B0 = 4'h1;
   localparam logic [3:0] SEL_B1 = 4'h2;
   localparam logic [3:0] SEL_B2 = 4'h4;
   localparam logic [3:0] SEL_B3 = 4'h8;
   localparam logic [3:0] SEL_H0 = 4'h3;
   localparam logic [3:0] SEL_H1 = 4'hC;
   localparam logic [3:0] SEL_W  = 4'hF;

   function automatic logic sel_legal(input logic [3:0] sel);
      case (sel)
         SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Selected lanes take the store data, the rest keep the word read back.
   function automatic logic [31:0] lane_merge(input logic [3:0]  sel,
                                              input logic [31:0] wdat,
                                              input logic [31:0] rdat);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : rdat[8*i +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/t5_dwb_ram.sv
// Data-bus responder for the t5 core backed by a single-port SRAM without
// byte enables; partial stores are read-modify-write, illegal requests get dwb_err.
module t5_dwb_ram
   import t5_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 10,
   parameter int BASE = 0,
   parameter int WAIT = 0
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            sys_ena,
   input  logic [XLEN-1:2] dwb_adr,
   input  logic [XLEN-1:0] dwb_dto,
   input  logic [3:0]      dwb_sel,
   input  logic            dwb_stb,
   input  logic            dwb_wre,
   output logic            dwb_ack,
   output logic            dwb_err,
   output logic [XLEN-1:0] dwb_dti,
   output logic [AW-1:0]   mem_adr,
   output logic            mem_ce,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_wdat,
   input  logic [XLEN-1:0] mem_rdat
);

   localparam int BW = XLEN - AW - 2;
   localparam logic [BW-1:0] BASE_V = BW'(BASE);

   state_e          state_q, state_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [3:0]      sel_q, sel_d;
   logic [XLEN-1:0] dto_q, dto_d;
   logic            wre_q, wre_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] dti_q, dti_d;
   logic            wt_done;
   logic            req_ok;

   assign req_ok  = sel_legal(dwb_sel) && (dwb_adr[XLEN-1:AW+2] == BASE_V);
   assign dwb_ack = ack_q;
   assign dwb_err = err_q;
   assign dwb_dti = dti_q;

   // Request fields are captured at acceptance so an early stb drop cannot corrupt the RMW.
   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      dto_d    = dto_q;
      wre_d    = wre_q;
      ack_d    = ack_q;
      err_d    = err_q;
      dti_d    = dti_q;
      mem_ce   = 1'b0;
      mem_we   = 1'b0;
      mem_adr  = '0;
      mem_wdat = '0;
      // Reset gates the SRAM strobes combinationally so they drop at once.
      if (sys_ena && sys_rst) begin
         ack_d = 1'b0;
         err_d = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (dwb_stb) begin
                  adr_d = dwb_adr[AW+1:2];
                  sel_d = dwb_sel;
                  dto_d = dwb_dto;
                  wre_d = dwb_wre;
                  if (!req_ok) begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end else if (dwb_wre && dwb_sel == SEL_W) begin
                     mem_ce   = 1'b1;
                     mem_we   = 1'b1;
                     mem_adr  = dwb_adr[AW+1:2];
                     mem_wdat = dwb_dto;
                     state_d  = (WAIT > 0) ? ST_WT : ST_RESP;
                     ack_d    = (WAIT == 0);
                  end else begin
                     mem_ce  = 1'b1;
                     mem_adr = dwb_adr[AW+1:2];
                     state_d = ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (wre_q) begin
                  mem_ce   = 1'b1;
                  mem_we   = 1'b1;
                  mem_adr  = adr_q;
                  mem_wdat = lane_merge(sel_q, dto_q, mem_rdat);
               end else begin
                  dti_d = mem_rdat;
               end
               state_d = (WAIT > 0) ? ST_WT : ST_RESP;
               ack_d   = (WAIT == 0);
            end
            ST_WT: begin
               if (wt_done) begin
                  state_d = ST_RESP;
                  ack_d   = 1'b1;
               end
            end
            ST_RESP, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         sel_q   <= '0;
         dto_q   <= '0;
         wre_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dti_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dto_q   <= dto_d;
         wre_q   <= wre_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dti_q   <= dti_d;
      end
   end

   generate
      if (WAIT > 0) begin : g_wait
         logic [2:0] cnt_q, cnt_d;

         assign wt_done = (cnt_q == 3'(WAIT - 1));

         always_comb begin
            cnt_d = cnt_q;
            if (sys_ena && state_q == ST_WT) begin
               cnt_d = wt_done ? 3'd0 : cnt_q + 3'd1;
            end
         end

         always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end else begin : g_nowait
         assign wt_done = 1'b1;
      end
   endgenerate

endmodule

// File: doc/t5_dwb_ram.md
# t5_dwb_ram

Synthesizable data-bus responder for the t5 core: it answers the `dwb_*` requests issued by `t5_cpu` and backs them with a single-port synchronous SRAM macro that has no byte enables. It decodes the request, inserts a fixed number of wait states, and pulses `dwb_ack`. Sub-word stores are done as read-modify-write. Illegal requests are answered with `dwb_err`. It sits between the CPU data port and on-chip data RAM.

## Interface
- `XLEN`, 32: bus width; only 32 is supported, since `dwb_sel` is 4 bits.
- `AW`, 10: SRAM word-address width (depth 2^AW words).
- `BASE`, 0: value required on `dwb_adr[XLEN-1:AW+2]` for an in-range access.
- `WAIT`, 0: extra wait states before the response (0..7).
- `sys_clk`  in  1: sole clock, rising edge.
- `sys_rst`  in  1: reset, asynchronous, active-low.
- `sys_ena`  in  1: clock enable; when low, all state holds and `mem_ce`=0.
- `dwb_adr`  in  XLEN-2: word address `[XLEN-1:2]`.
- `dwb_dto`  in  XLEN: store data.
- `dwb_sel`  in  4: byte-lane select; bit i selects bits 8i+7:8i.
- `dwb_stb`  in  1: request strobe.
- `dwb_wre`  in  1: 1 = write.
- `dwb_ack`  out 1: one-cycle completion pulse.
- `dwb_err`  out 1: one-cycle error pulse, replacing `dwb_ack`.
- `dwb_dti`  out XLEN: load data; valid while `dwb_ack`=1 and held until the next read completes.
- `mem_adr`  out AW: SRAM address (`dwb_adr[AW+1:2]`).
- `mem_ce`   out 1: SRAM enable.
- `mem_we`   out 1: SRAM write.
- `mem_wdat` out XLEN: SRAM write data.
- `mem_rdat` in  XLEN: SRAM read data. It is valid one cycle after a read with `mem_ce`=1 and is held while `mem_ce`=0.

## Operation
- **Legal select values:** 1, 2, 4, 8, 3, C, F.
- **Legal address:** upper bits of `dwb_adr` equal `BASE`.
- **Bus protocol:**
  - The master holds `dwb_adr`, `dwb_dto`, `dwb_sel` and `dwb_wre` stable while `dwb_stb` is high, until it sees ack or err.
  - The responder ignores `dwb_stb` in the cycle its own ack or err is high. Back-to-back requests are therefore accepted no earlier than the cycle after a response.
- **FSM states:** IDLE, RD, WT, RESP, ERR.
- **Transitions out of IDLE**, when `dwb_stb`=1 and no response pulse is active:
  - Illegal select or address → ERR. No memory access.
  - Write with select F → `mem_ce`=`mem_we`=1 and `mem_wdat`=`dwb_dto` in this cycle; next state is WT if `WAIT`>0, else RESP.
  - Read, or write with a partial select → `mem_ce`=1 and `mem_we`=0 in this cycle; next state RD.
- **RD:**
  - On a read, capture `mem_rdat` into `dwb_dti`.
  - On a partial write, drive `mem_ce`=`mem_we`=1 with `mem_wdat` set to the lane merge: lanes with sel=1 take `dwb_dto`, the other lanes take `mem_rdat`.
  - Next state WT if `WAIT`>0, else RESP.
- **WT:** the wait counter counts `WAIT` cycles, then the FSM goes to RESP.
- **RESP:** `dwb_ack`=1 for one cycle, then IDLE.
- **ERR:** `dwb_err`=1 for one cycle, then IDLE.
- **Read data:** a read always returns the full word; the master extracts the lanes.
- **Master drops `dwb_stb` early** (protocol violation): the transaction still completes, including any memory write, and the response pulses anyway.

## Timing
- **Reference cycle:** N is the cycle in which IDLE samples `dwb_stb`=1.
- **Full-word write:** memory write in N; `dwb_ack` in N+1+`WAIT`.
- **Read:** memory read in N; `dwb_dti` updates at the edge ending N+1; `dwb_ack` in N+2+`WAIT`.
- **Partial write:** read in N, merged write in N+1; `dwb_ack` in N+2+`WAIT`.
- **Error:** `dwb_err` in N+1; `mem_ce` stays 0 throughout.
- **Reset values:** state IDLE, wait counter 0, `dwb_ack`=0, `dwb_err`=0, `dwb_dti`=0, `mem_ce`=0, `mem_we`=0, `mem_adr`=0, `mem_wdat`=0.
- **Reset during a transaction:**
  - During RD, a partial write is abandoned and the memory word is unchanged.
  - A full write already issued in N stays committed.
  - No ack is produced for an aborted transaction.
- **`sys_ena`=0:** the FSM and wait counter freeze. An RD frozen in place uses the held `mem_rdat` when `sys_ena` returns.

## Structure
- **Shared package `t5_pkg`:**
  - FSM state enum.
  - `sel_legal(sel)` function.
  - `lane_merge(sel, new, old)` function.
  - `SEL_*` constants.
- **No sub-module.** The FSM, wait counter and merge stay in one module, with `WAIT` handled by a generate-guarded counter.

## Test plan
All cases use `AW`=10, `BASE`=0, `WAIT`=0 unless stated.
- **Full write then read:** write adr word 1, `dwb_dto`=DEADBEEF, sel=F → `mem_we` in N with `mem_adr`=1 and ack in N+1. Read of word 1 → ack in N+2 with `dwb_dti`=DEADBEEF.
- **Partial write:** word 1 = DEADBEEF; write sel=2, `dwb_dto`=0000A500 → merged write DEADA5EF in N+1, ack in N+2. Readback gives DEADA5EF.
- **Illegal select:** sel=5 → `dwb_err` in N+1 and never `dwb_ack`; `mem_ce`=0 throughout; memory unchanged.
- **Out-of-range address:** word address 0x400 (upper bits ≠ `BASE`) → `dwb_err` in N+1, no memory access.
- **Wait states:** `WAIT`=3, read → ack exactly in N+5. Back-to-back reads with `dwb_stb` held high → one ack per request, never two consecutive ack cycles.
- **Reset mid-write:** assert `sys_rst` low during RD of a sel=8 write → all outputs 0 immediately, no ack, word unchanged. The next request completes normally.
